uart_transmitter: RTL and testbench

Serialises one byte per request onto the UART TX line as 8N1: start bit, 8 data bits LSB first, 1 stop bit. It is the sending end of the serial link, so its o_tx_serial drives the line that the UART receive stage samples. A single-entry request/ready handshake accepts bytes from the host logic. It signals line activity and frame completion.

---
 rtl/uart_transmitter.sv | 185 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Purpose: serialises one byte per accepted request onto a UART TX line as
// 8N1 (start bit, 8 data bits LSB first, stop bit). Optional even parity
// bit between the data and stop bits when UART_TX_PARITY_EN is defined
// (frame then becomes 8E1, 11 bit periods long).
//
// Parameters:
//   CLKs_Per_Bit - i_clk cycles per bit period (>= 2)
//
// Ports:
//   i_clk       - system clock, rising edge
//   i_rst_n     - asynchronous active-low reset
//   i_tx_DV     - request: i_tx_byte valid, send it
//   i_tx_byte   - byte to send, sampled only on accept
//   o_tx_ready  - high when a request will be accepted this cycle
//   o_tx_serial - UART line, idles high
//   o_tx_active - high while start/data/(parity)/stop bits are on the line
//   o_tx_done   - one-cycle pulse after the stop bit completes
//
// Optional feature macro: UART_TX_PARITY_EN
// ---------------------------------------------------------------------------
module uart_transmitter #(
  parameter int CLKs_Per_Bit = 87
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_DV,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done
);

  localparam int            CW       = $clog2(CLKs_Per_Bit) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKs_Per_Bit - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;

  logic          bit_end;
  logic [2:0]    idx_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      serial_q <= serial_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so every output comes straight
  // from a flop; the _d values describe what the line shows after the edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    serial_d = serial_q;
    active_d = active_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    bit_end  = (cnt_q == CNT_LAST);
    idx_next = idx_q + 3'd1;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        ready_d  = 1'b1;
        cnt_d    = '0;
        if (i_tx_DV && ready_q) begin
          byte_d   = i_tx_byte;
          state_d  = START;
          serial_d = 1'b0;
          active_d = 1'b1;
          ready_d  = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d  = DATA;
          cnt_d    = '0;
          idx_d    = 3'd0;
          serial_d = byte_q[0];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          // Leave DATA on index 7 instead of incrementing, so the 3-bit
          // index never wraps back to 0 while data bits are being sent.
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            serial_d = ^byte_q;
`else
            state_d  = STOP;
            serial_d = 1'b1;
`endif
          end else begin
            idx_d    = idx_next;
            serial_d = byte_q[idx_next];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          cnt_d    = '0;
          serial_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          // Done cycle: ready rises together with done, so a request held
          // during this cycle is taken on the next edge.
          state_d  = IDLE;
          cnt_d    = '0;
          serial_d = 1'b1;
          active_d = 1'b0;
          ready_d  = 1'b1;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        serial_d = 1'b1;
        active_d = 1'b0;
        ready_d  = 1'b1;
      end
    endcase
  end

  assign o_tx_ready  = ready_q;
  assign o_tx_serial = serial_q;
  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Directed bench for uart_transmitter with CLKs_Per_Bit = 4. Inputs are
// driven and outputs sampled on the falling clock edge; the DUT acts on the
// rising edge. Honors UART_TX_PARITY_EN for frame length and parity tests.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk;
  logic       rst_n;
  logic       i_tx_DV;
  logic [7:0] i_tx_byte;
  logic       o_tx_ready;
  logic       o_tx_serial;
  logic       o_tx_active;
  logic       o_tx_done;

  int checks;
  int errors;
  int cyc;
  int last_done;
  int first_done;

  uart_transmitter #(.CLKs_Per_Bit(CPB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tx_DV    (i_tx_DV),
    .i_tx_byte  (i_tx_byte),
    .o_tx_ready (o_tx_ready),
    .o_tx_serial(o_tx_serial),
    .o_tx_active(o_tx_active),
    .o_tx_done  (o_tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_serial"}, 32'(o_tx_serial), 32'd1);
      chk({tag, "_ready"},  32'(o_tx_ready),  32'd1);
      chk({tag, "_active"}, 32'(o_tx_active), 32'd0);
      chk({tag, "_done"},   32'(o_tx_done),   32'd0);
    end
  endtask

  // Called on a falling edge where the DUT is ready. Requests b, checks every
  // cycle of the frame and ends on the done cycle. hold keeps i_tx_DV high
  // with hold_b during the whole frame; inj_k >= 1 pulses an extra request
  // with inj_b at that cycle of the frame.
  task automatic run_frame(input logic [7:0] b, input bit hold, input logic [7:0] hold_b,
                           input int inj_k, input logic [7:0] inj_b, input logic par);
    logic [NBITS-1:0] slots;
    int acc;
    acc = 0;
`ifdef UART_TX_PARITY_EN
    slots = {1'b1, par, b, 1'b0};
`else
    slots = {1'b1, b, 1'b0};
`endif
    chk("ready_before_accept", 32'(o_tx_ready), 32'd1);
    i_tx_DV   = 1'b1;
    i_tx_byte = b;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == 0) begin
        acc = cyc;
        if (hold) begin
          i_tx_DV   = 1'b1;
          i_tx_byte = hold_b;
        end else begin
          i_tx_DV   = 1'b0;
          i_tx_byte = ~b;
        end
      end else if (k == inj_k) begin
        i_tx_DV   = 1'b1;
        i_tx_byte = inj_b;
      end else if (k == inj_k + 1) begin
        i_tx_DV = 1'b0;
      end
      chk("frame_serial", 32'(o_tx_serial), 32'(slots[k / CPB]));
      chk("frame_active", 32'(o_tx_active), 32'd1);
      chk("frame_ready",  32'(o_tx_ready),  32'd0);
      chk("frame_done",   32'(o_tx_done),   32'd0);
    end
    @(negedge clk);
    chk("done_pulse",  32'(o_tx_done),   32'd1);
    chk("done_serial", 32'(o_tx_serial), 32'd1);
    chk("done_active", 32'(o_tx_active), 32'd0);
    chk("done_ready",  32'(o_tx_ready),  32'd1);
    chk("done_latency", 32'(cyc - acc),  32'(FRAME));
    last_done = cyc;
    $display("frame byte=%02h accept_cyc=%0d done_cyc=%0d", b, acc, cyc);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_done = 0;
    first_done = 0;
    rst_n     = 1'b1;
    i_tx_DV   = 1'b0;
    i_tx_byte = 8'h00;

    // Reset state, then 50 idle cycles after release.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_serial", 32'(o_tx_serial), 32'd1);
    chk("rst_ready",  32'(o_tx_ready),  32'd1);
    chk("rst_active", 32'(o_tx_active), 32'd0);
    chk("rst_done",   32'(o_tx_done),   32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_check(50, "idle_after_reset");
    $display("reset/idle: 50 cycles checked");

    // 0x55: alternating line levels, done 40 cycles after accept.
    run_frame(8'h55, 1'b0, 8'h00, -1, 8'h00, 1'b0);
    idle_check(5, "idle_after_55");

    // Back-to-back 0xA5 then 0x3C with DV held high during the first frame.
    run_frame(8'hA5, 1'b1, 8'h3C, -1, 8'h00, 1'b0);
    first_done = last_done;
    run_frame(8'h3C, 1'b0, 8'h00, -1, 8'h00, 1'b0);
    chk("b2b_done_spacing", 32'(last_done - first_done), 32'(FRAME + 1));
    $display("back-to-back: done spacing %0d", last_done - first_done);
    idle_check(5, "idle_after_b2b");

    // 0x0F with a 0xFF request pulsed at cycle 12: must be dropped.
    run_frame(8'h0F, 1'b0, 8'h00, 12, 8'hFF, 1'b0);
    idle_check(FRAME + 10, "idle_after_drop");
    $display("dropped request: no second frame");

    // Reset at cycle 15 of a 0x00 frame.
    i_tx_DV   = 1'b1;
    i_tx_byte = 8'h00;
    @(negedge clk);
    i_tx_DV = 1'b0;
    chk("pre_rst_active", 32'(o_tx_active), 32'd1);
    repeat (15) @(negedge clk);
    chk("pre_rst_serial", 32'(o_tx_serial), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_serial", 32'(o_tx_serial), 32'd1);
    chk("async_rst_active", 32'(o_tx_active), 32'd0);
    chk("async_rst_ready",  32'(o_tx_ready),  32'd1);
    chk("async_rst_done",   32'(o_tx_done),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_check(FRAME + 10, "idle_after_midrst");
    $display("mid-frame reset: line high, no done");
    run_frame(8'h81, 1'b0, 8'h00, -1, 8'h00, 1'b0);
    idle_check(3, "idle_after_81");

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 has three ones -> 1, 0x03 has two ones -> 0.
    run_frame(8'h07, 1'b0, 8'h00, -1, 8'h00, 1'b1);
    idle_check(3, "idle_after_07");
    run_frame(8'h03, 1'b0, 8'h00, -1, 8'h00, 1'b0);
    idle_check(3, "idle_after_03");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
